// File: rtl/ysyx_23060077_idu_queue.sv
// rtl/ysyx_23060077_idu_queue.sv - RV32I/M decoder feeding an in-order decoded micro-op FIFO
// Illegal encodings are still queued so the exception reaches EXU in program order.
module ysyx_23060077_idu_queue #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  parameter int EN_M  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [10:0]              out_class,
  output logic [2:0]               out_funct3,
  output logic                     out_alt,
  output logic                     out_muldiv,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [10:0]     cls;
    logic [2:0]      funct3;
    logic            alt;
    logic            muldiv;
    logic            illegal;
  } uop_t;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, imm_b, imm_s, imm_sys;
  logic [XLEN-1:0] imm_sel;
  logic [10:0]     cls;
  logic            bad, use_rd, use_rs1, use_rs2;
  uop_t            dec;

  assign opcode  = in_inst[6:0];
  assign f3      = in_inst[14:12];
  assign f7      = in_inst[31:25];
  assign imm_i   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u   = {in_inst[31:12], 12'b0};
  assign imm_j   = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_b   = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_s   = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_sys = {{(XLEN-17){in_inst[31]}}, in_inst[31:15]};

  always_comb begin
    cls     = '0;
    bad     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_sel = '0;
    case (opcode)
      OPC_LUI:    begin cls[0] = 1'b1; use_rd = 1'b1; imm_sel = imm_u; end
      OPC_AUIPC:  begin cls[1] = 1'b1; use_rd = 1'b1; imm_sel = imm_u; end
      OPC_JAL:    begin cls[2] = 1'b1; use_rd = 1'b1; imm_sel = imm_j; end
      OPC_JALR: begin
        cls[3] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; imm_sel = imm_i;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        cls[4] = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = imm_b;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        cls[5] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; imm_sel = imm_i;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        cls[6] = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = imm_s;
        bad = (f3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        cls[7] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; imm_sel = imm_i;
        // Shifts reuse imm[11:5] as funct7; only SRAI may set bit 30.
        if (f3 == 3'b001) bad = (f7 != 7'b0000000);
        else if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        cls[8] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                ((f7 == 7'b0000001) && (EN_M != 0)));
      end
      OPC_FENCE:  begin cls[9] = 1'b1; end
      OPC_SYS:    begin cls[10] = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; imm_sel = imm_sys; end
      default:    bad = 1'b1;
    endcase

    dec.pc      = in_pc;
    dec.funct3  = f3;
    dec.alt     = in_inst[30];
    dec.illegal = bad;
    dec.cls     = bad ? 11'b0 : cls;
    dec.rd      = (use_rd  && !bad) ? in_inst[11:7]  : 5'd0;
    dec.rs1     = (use_rs1 && !bad) ? in_inst[19:15] : 5'd0;
    dec.rs2     = (use_rs2 && !bad) ? in_inst[24:20] : 5'd0;
    dec.imm     = bad ? '0 : imm_sel;
    dec.muldiv  = cls[8] && (f7 == 7'b0000001) && !bad;
  end

  uop_t             mem_q [DEPTH];
  uop_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  uop_t             head;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = dec;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_class   = head.cls;
  assign out_funct3  = head.funct3;
  assign out_alt     = head.alt;
  assign out_muldiv  = head.muldiv;
  assign out_illegal = head.illegal;
  assign count       = count_q;

endmodule

// File: tb/tb_ysyx_23060077_idu_queue.sv
// tb/tb_ysyx_23060077_idu_queue.sv - directed table plus scoreboarded stream for the decode queue
module tb_ysyx_23060077_idu_queue;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready1, out_valid1, alt1, md1, ill1;
  logic [31:0] pc1, imm1;
  logic [4:0]  rd1, rs1_1, rs2_1;
  logic [10:0] cls1;
  logic [2:0]  f3_1;
  logic [2:0]  cnt1;

  logic        in_ready0, out_valid0, alt0, md0, ill0;
  logic [31:0] pc0, imm0;
  logic [4:0]  rd0, rs1_0, rs2_0;
  logic [10:0] cls0;
  logic [2:0]  f3_0;
  logic [2:0]  cnt0;

  always #5 clock = ~clock;

  ysyx_23060077_idu_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH), .EN_M(1)) dut_m1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(pc1), .out_rd(rd1), .out_rs1(rs1_1), .out_rs2(rs2_1), .out_imm(imm1),
    .out_class(cls1), .out_funct3(f3_1), .out_alt(alt1), .out_muldiv(md1),
    .out_illegal(ill1), .count(cnt1));

  ysyx_23060077_idu_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH), .EN_M(0)) dut_m0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(pc0), .out_rd(rd0), .out_rs1(rs1_0), .out_rs2(rs2_0), .out_imm(imm0),
    .out_class(cls0), .out_funct3(f3_0), .out_alt(alt0), .out_muldiv(md0),
    .out_illegal(ill0), .count(cnt0));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [10:0] cls;
    logic [2:0]  f3;
    logic        alt, md, ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [10:0] cls;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill, md, ill_m0;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  vec_t vt[20];
  logic [6:0] ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  task automatic chk(input string nm, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input ent_t e, input bit en_m);
    exp_t r;
    logic [31:0] i;
    logic [2:0] f3;
    logic [6:0] f7;
    bit urd, urs1, urs2;
    i = e.inst; f3 = i[14:12]; f7 = i[31:25];
    r = '0; r.pc = e.pc; r.f3 = f3; r.alt = i[30];
    urd = 0; urs1 = 0; urs2 = 0;
    case (i[6:0])
      7'h37: begin r.cls = 11'h001; urd = 1; r.imm = {i[31:12], 12'h000}; end
      7'h17: begin r.cls = 11'h002; urd = 1; r.imm = {i[31:12], 12'h000}; end
      7'h6F: begin r.cls = 11'h004; urd = 1;
                   r.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
      7'h67: begin r.cls = 11'h008; urd = 1; urs1 = 1;
                   r.imm = {{20{i[31]}}, i[31:20]}; r.ill = (f3 != 0); end
      7'h63: begin r.cls = 11'h010; urs1 = 1; urs2 = 1;
                   r.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                   r.ill = (f3 == 2) || (f3 == 3); end
      7'h03: begin r.cls = 11'h020; urd = 1; urs1 = 1;
                   r.imm = {{20{i[31]}}, i[31:20]}; r.ill = (f3 == 3) || (f3 >= 6); end
      7'h23: begin r.cls = 11'h040; urs1 = 1; urs2 = 1;
                   r.imm = {{20{i[31]}}, i[31:25], i[11:7]}; r.ill = (f3 >= 3); end
      7'h13: begin r.cls = 11'h080; urd = 1; urs1 = 1; r.imm = {{20{i[31]}}, i[31:20]};
                   if (f3 == 1) r.ill = (f7 != 0);
                   if (f3 == 5) r.ill = !(f7 == 0 || f7 == 7'h20); end
      7'h33: begin r.cls = 11'h100; urd = 1; urs1 = 1; urs2 = 1; r.md = (f7 == 1);
                   r.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m)); end
      7'h0F: r.cls = 11'h200;
      7'h73: begin r.cls = 11'h400; urd = 1; urs1 = 1; r.imm = {{15{i[31]}}, i[31:15]}; end
      default: r.ill = 1;
    endcase
    if (urd)  r.rd  = i[11:7];
    if (urs1) r.rs1 = i[19:15];
    if (urs2) r.rs2 = i[24:20];
    if (r.ill) begin
      r.cls = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.imm = 0; r.md = 0;
    end
    return r;
  endfunction

  task automatic check_state(input string tag);
    exp_t e1, e0;
    chk({tag, " count"}, 97'(cnt1), 97'(q.size()));
    chk({tag, " count_m0"}, 97'(cnt0), 97'(q.size()));
    chk({tag, " out_valid"}, 97'(out_valid1), 97'(q.size() != 0));
    chk({tag, " in_ready"}, 97'(in_ready1), 97'(q.size() < DEPTH));
    if (q.size() != 0) begin
      e1 = model(q[0], 1'b1);
      e0 = model(q[0], 1'b0);
      chk({tag, " head_m1"}, {pc1, rd1, rs1_1, rs2_1, imm1, cls1, f3_1, alt1, md1, ill1}, e1);
      chk({tag, " head_m0"}, {pc0, rd0, rs1_0, rs2_0, imm0, cls0, f3_0, alt0, md0, ill0}, e0);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit r, input bit fl, input bit rst, input string tag);
    bit push, pop;
    push = v && (q.size() < DEPTH) && !fl && !rst;
    pop  = r && (q.size() != 0) && !fl && !rst;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = r; flush = fl; reset = rst;
    @(posedge clock);
    #1;
    if (rst || fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{inst: inst, pc: pc});
    end
    check_state(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      i[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: i[31:25] = 7'h00;
        1: i[31:25] = 7'h20;
        2: i[31:25] = 7'h01;
        default: ;
      endcase
    end
    return i;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] vi;
    logic [2:0]  xf3;
    vt[0]  = '{32'h00500093, 11'h080, 5'd1, 5'd0, 5'd0, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h0020A423, 11'h040, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'h022081B3, 11'h100, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{32'h00000000, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{32'h123452B7, 11'h001, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h008000EF, 11'h004, 5'd1, 5'd0, 5'd0, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'hFE000EE3, 11'h010, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'hFFC12183, 11'h020, 5'd3, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h402081B3, 11'h100, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'h4030D093, 11'h080, 5'd1, 5'd1, 5'd0, 32'h00000403, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'h40109093, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[11] = '{32'h000090E7, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[12] = '{32'h300110F3, 11'h400, 5'd1, 5'd2, 5'd0, 32'h00006002, 1'b0, 1'b0, 1'b0};
    vt[13] = '{32'h0FF0000F, 11'h200, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vt[14] = '{32'h00001117, 11'h002, 5'd2, 5'd0, 5'd0, 32'h00001000, 1'b0, 1'b0, 1'b0};
    vt[15] = '{32'hFE110FA3, 11'h040, 5'd0, 5'd2, 5'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[16] = '{32'h402091B3, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[17] = '{32'h00500091, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[18] = '{32'h027352B3, 11'h100, 5'd5, 5'd6, 5'd7, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vt[19] = '{32'h0000B183, 11'h000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    cycle(0, 0, 0, 0, 0, 1, "reset");
    cycle(0, 0, 0, 0, 0, 0, "idle");
    chk("idle in_ready", 97'(in_ready1), 97'(1));
    chk("idle out_valid", 97'(out_valid1), 97'(0));

    // Hand-decoded vectors, one at a time through an empty queue.
    for (int k = 0; k < 20; k++) begin
      v = vt[k];
      vi = v.inst;
      xf3 = vi[14:12];
      cycle(1, v.inst, 32'h80000000 + 32'(k * 4), 0, 0, 0, "vec_push");
      chk($sformatf("vec%0d m1", k), {pc1, cls1, rd1, rs1_1, rs2_1, imm1, ill1, md1, f3_1},
          {32'h80000000 + 32'(k * 4), v.cls, v.rd, v.rs1, v.rs2, v.imm, v.ill, v.md, xf3});
      if (v.ill_m0)
        chk($sformatf("vec%0d m0", k), {cls0, rd0, rs1_0, rs2_0, imm0, ill0, md0, f3_0},
            {11'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0, xf3});
      else
        chk($sformatf("vec%0d m0", k), {cls0, rd0, rs1_0, rs2_0, imm0, ill0, md0, f3_0},
            {v.cls, v.rd, v.rs1, v.rs2, v.imm, v.ill, v.md, xf3});
      cycle(0, 0, 0, 1, 0, 0, "vec_pop");
    end

    // Offset the pointers so the fill sequence wraps.
    cycle(1, vt[0].inst, 32'h100, 1, 0, 0, "skew");
    cycle(0, 0, 0, 1, 0, 0, "skew");
    for (int k = 0; k < DEPTH; k++)
      cycle(1, vt[k + 4].inst, 32'h200 + 32'(k * 4), 0, 0, 0, "fill");
    chk("full in_ready", 97'(in_ready1), 97'(0));
    chk("full count", 97'(cnt1), 97'(DEPTH));
    cycle(1, vt[12].inst, 32'h300, 0, 0, 0, "full_hold");
    cycle(1, vt[12].inst, 32'h300, 0, 0, 0, "full_hold");
    chk("full head pc", 97'(pc1), 97'(32'h200));
    cycle(1, vt[12].inst, 32'h300, 1, 0, 0, "full_pop");
    chk("full_pop count", 97'(cnt1), 97'(DEPTH - 1));
    chk("full_pop in_ready", 97'(in_ready1), 97'(1));
    cycle(1, vt[13].inst, 32'h304, 1, 0, 0, "push_pop");
    for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++)
      cycle(0, 0, 0, 1, 0, 0, "drain");

    // Flush with same-cycle push and pop.
    for (int k = 0; k < 3; k++) cycle(1, vt[k].inst, 32'h400 + 32'(k * 4), 0, 0, 0, "pre_flush");
    cycle(1, vt[14].inst, 32'h500, 1, 1, 0, "flush");
    chk("flush count", 97'(cnt1), 97'(0));
    cycle(0, 0, 0, 1, 0, 0, "post_flush");

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) cycle(1, vt[k + 7].inst, 32'h600 + 32'(k * 4), 0, 0, 0, "pre_reset");
    cycle(1, vt[15].inst, 32'h700, 1, 1, 1, "mid_reset");
    chk("mid_reset out_valid", 97'(out_valid1), 97'(0));

    for (int k = 0; k < 1000; k++)
      cycle($urandom_range(0, 3) != 0, rand_inst(), 32'h1000 + 32'(k * 4),
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, 1'b0, "stream");
    for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++)
      cycle(0, 0, 0, 1, 0, 0, "final_drain");
    chk("final empty", 97'(cnt1), 97'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
